// File: rtl/audio_fifo_sync.sv
// Single-clock sample FIFO with {lr,data} entries, fill level, thresholds and sticky errors; writes and reads stall (are rejected) on full/empty.
// Registered read by default (1-cycle latency); AUDIO_FIFO_FWFT_EN selects first-word fall-through output.
module audio_fifo_sync #(
  parameter int adr_width = 10,
  parameter int dat_width = 16,
  parameter int af_thresh = (1 << adr_width) - 4,
  parameter int ae_thresh = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [dat_width-1:0] data_in,
  input  logic                 lr_in,
  input  logic                 rd,
  output logic [dat_width-1:0] data_out,
  output logic                 lr_out,
  output logic                 rd_valid,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [adr_width:0]   level,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clr_err
);

  localparam int depth = 1 << adr_width;
  localparam logic [adr_width:0]   depth_lvl = depth[adr_width:0];
  localparam logic [adr_width:0]   af_lvl    = af_thresh[adr_width:0];
  localparam logic [adr_width:0]   ae_lvl    = ae_thresh[adr_width:0];
  localparam logic [adr_width-1:0] ptr_one   = 1;
  localparam logic [adr_width:0]   lvl_one   = 1;

  logic [dat_width:0]   mem_q [depth];
  logic [dat_width:0]   head;
  logic                 wr_acc, rd_acc;
  logic [adr_width-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [adr_width:0]   level_q, level_d;
  logic                 empty_q, empty_d, full_q, full_d;
  logic                 ae_q, ae_d, af_q, af_d;
  logic                 ovf_q, ovf_d, udf_q, udf_d;

  assign head = mem_q[r_ptr_q];

  // Storage is not reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[w_ptr_q] <= {lr_in, data_in};
  end

  always_comb begin
    wr_acc  = wr & ~full_q;
    rd_acc  = rd & ~empty_q;
    w_ptr_d = wr_acc ? w_ptr_q + ptr_one : w_ptr_q;
    r_ptr_d = rd_acc ? r_ptr_q + ptr_one : r_ptr_q;
    level_d = level_q;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + lvl_one;
      2'b01:   level_d = level_q - lvl_one;
      default: level_d = level_q;
    endcase
    // Flags follow the next level so they line up with level in the same cycle.
    empty_d = (level_d == '0);
    full_d  = (level_d == depth_lvl);
    ae_d    = (level_d <= ae_lvl);
    af_d    = (level_d >= af_lvl);
    ovf_d   = (ovf_q & ~clr_err) | (wr & full_q);
    udf_d   = (udf_q & ~clr_err) | (rd & empty_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign level        = level_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

`ifdef AUDIO_FIFO_FWFT_EN
  // Masked while empty so the output reads zero out of reset rather than stale storage.
  assign data_out = empty_q ? '0 : head[dat_width-1:0];
  assign lr_out   = empty_q ? 1'b0 : head[dat_width];
  assign rd_valid = ~empty_q;
`else
  logic [dat_width-1:0] dout_q, dout_d;
  logic                 lr_q, lr_d, rv_q, rv_d;

  always_comb begin
    dout_d = rd_acc ? head[dat_width-1:0] : dout_q;
    lr_d   = rd_acc ? head[dat_width] : lr_q;
    rv_d   = rd_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_q <= '0;
      lr_q   <= 1'b0;
      rv_q   <= 1'b0;
    end else begin
      dout_q <= dout_d;
      lr_q   <= lr_d;
      rv_q   <= rv_d;
    end
  end

  assign data_out = dout_q;
  assign lr_out   = lr_q;
  assign rd_valid = rv_q;
`endif

endmodule
